// File: rtl/safe_pkg.sv
// Shared types and constants for the safe-cracking scoring core.
// The popcount helper is used for both the correct and the misplaced counts.
package safe_pkg;

    localparam int DIGIT_W    = 2;
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = 4;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [3:0]         bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Number of set bits in a per-digit flag vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_DIGITS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/safe_match_comb.sv
// Combinational Mastermind scoring: exact-position matches plus a greedy
// misplaced match in which each code digit can be claimed at most once.
module safe_match_comb
    import safe_pkg::*;
(
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
    output logic [NUM_DIGITS-1:0]         correct_flags,
    output logic [NUM_DIGITS-1:0]         misplaced_flags,
    output logic [CNT_W-1:0]              correct_count,
    output logic [CNT_W-1:0]              misplaced_count
);

    logic [NUM_DIGITS-1:0] w_correct;
    logic [NUM_DIGITS-1:0] w_misplaced;
    logic [NUM_DIGITS-1:0] w_consumed;
    logic                  w_found;
    logic                  w_hit;

    // Per-position equality of guess and code digits.
    always_comb begin
        w_correct = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_correct[k] = (guess[k*DIGIT_W +: DIGIT_W] == code[k*DIGIT_W +: DIGIT_W]);
        end
    end

    // Greedy scan: each unmatched guess digit claims the lowest free, unmatched code digit.
    always_comb begin
        w_misplaced = '0;
        w_consumed  = '0;
        w_found     = 1'b0;
        w_hit       = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_found = 1'b0;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                w_hit = !w_correct[i] && !w_found && !w_correct[j] && !w_consumed[j] &&
                        (code[j*DIGIT_W +: DIGIT_W] == guess[i*DIGIT_W +: DIGIT_W]);
                w_consumed[j] = w_consumed[j] | w_hit;
                w_found       = w_found | w_hit;
            end
            w_misplaced[i] = w_found;
        end
    end

    assign correct_flags   = w_correct;
    assign misplaced_flags = w_misplaced;
    assign correct_count   = popcount(w_correct);
    assign misplaced_count = popcount(w_misplaced);

endmodule

// File: rtl/safe_guess_evaluator.sv
// Safe-cracking scoring core: digit-enable decoder, guess scoring, latched
// results and a BCD attempt counter that ends the game after 100 submits.
module safe_guess_evaluator
    import safe_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    sel,
    output logic [NUM_DIGITS-1:0]         enables,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
    input  logic                          submit,
    output logic [NUM_DIGITS-1:0]         correct_flags,
    output logic [NUM_DIGITS-1:0]         misplaced_flags,
    output logic [CNT_W-1:0]              correct_count,
    output logic [CNT_W-1:0]              misplaced_count,
    output logic [CNT_W-1:0]              total_correct,
    output logic [CNT_W-1:0]              total_misplaced,
    output logic [7:0]                    attempts,
    output logic                          lose,
    output logic                          solved
);

    logic [NUM_DIGITS-1:0] w_enables;
    logic [CNT_W-1:0]      w_correct_count;
    logic [CNT_W-1:0]      w_misplaced_count;
    logic                  w_accept;

    logic [CNT_W-1:0]      r_total_correct;
    logic [CNT_W-1:0]      r_total_misplaced;
    bcd_t                  r_tens;
    bcd_t                  r_ones;
    logic                  r_lose;
    logic                  r_solved;

    // One-hot digit enable from the scroll position.
    always_comb begin
        w_enables      = '0;
        w_enables[sel] = 1'b1;
    end

    safe_match_comb u_match (
        .guess           (guess),
        .code            (code),
        .correct_flags   (correct_flags),
        .misplaced_flags (misplaced_flags),
        .correct_count   (w_correct_count),
        .misplaced_count (w_misplaced_count)
    );

    // Once the game is decided, further submits are ignored until reset.
    assign w_accept = submit && !r_lose && !r_solved;

    // Result latch, attempt counter and end-of-game flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total_correct   <= '0;
            r_total_misplaced <= '0;
            r_tens            <= 4'd0;
            r_ones            <= 4'd0;
            r_lose            <= 1'b0;
            r_solved          <= 1'b0;
        end else if (w_accept) begin
            r_total_correct   <= w_correct_count;
            r_total_misplaced <= w_misplaced_count;
            if (w_correct_count == 4'd4) begin
                r_solved <= 1'b1;
            end
            // At 99 the counter saturates and the 100th submit loses.
            if ((r_tens == BCD_MAX) && (r_ones == BCD_MAX)) begin
                r_lose <= 1'b1;
            end else if (r_ones != BCD_MAX) begin
                r_ones <= r_ones + 4'd1;
            end else begin
                r_tens <= r_tens + 4'd1;
                r_ones <= 4'd0;
            end
        end
    end

    assign enables         = w_enables;
    assign correct_count   = w_correct_count;
    assign misplaced_count = w_misplaced_count;
    assign total_correct   = r_total_correct;
    assign total_misplaced = r_total_misplaced;
    assign attempts        = {r_tens, r_ones};
    assign lose            = r_lose;
    assign solved          = r_solved;

endmodule

// File: tb/tb_safe_guess_evaluator.sv
// Self-checking bench for safe_guess_evaluator: table of combinational
// scoring vectors plus scoreboarded multi-cycle submit sequences.
module tb_safe_guess_evaluator;

    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic [3:0] enables;
    logic [7:0] guess;
    logic [7:0] code;
    logic       submit;
    logic [3:0] correct_flags;
    logic [3:0] misplaced_flags;
    logic [3:0] correct_count;
    logic [3:0] misplaced_count;
    logic [3:0] total_correct;
    logic [3:0] total_misplaced;
    logic [7:0] attempts;
    logic       lose;
    logic       solved;

    int total = 0;
    int bad   = 0;

    safe_guess_evaluator dut (
        .clk             (clk),
        .reset           (reset),
        .sel             (sel),
        .enables         (enables),
        .guess           (guess),
        .code            (code),
        .submit          (submit),
        .correct_flags   (correct_flags),
        .misplaced_flags (misplaced_flags),
        .correct_count   (correct_count),
        .misplaced_count (misplaced_count),
        .total_correct   (total_correct),
        .total_misplaced (total_misplaced),
        .attempts        (attempts),
        .lose            (lose),
        .solved          (solved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] guess;
        logic [7:0] code;
        logic [3:0] en;
        logic [3:0] c;
        logic [3:0] m;
        logic [3:0] cc;
        logic [3:0] mc;
    } vec_t;

    typedef struct {
        logic [3:0] tc;
        logic [3:0] tm;
        logic [7:0] att;
        logic       lose;
        logic       solved;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    // Bench-side game model
    logic [3:0] m_tc;
    logic [3:0] m_tm;
    int         m_n;
    logic       m_lose;
    logic       m_solved;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle with the given reset/submit; cc/mc are the known scores of the current guess.
    task automatic step(input logic rst, input logic sub, input logic [3:0] cc, input logic [3:0] mc);
        exp_t e;
        exp_t got;
        reset  = rst;
        submit = sub;
        if (rst) begin
            m_tc = 4'd0; m_tm = 4'd0; m_n = 0; m_lose = 1'b0; m_solved = 1'b0;
        end else if (sub && !m_lose && !m_solved) begin
            m_tc = cc;
            m_tm = mc;
            if (cc == 4'd4) m_solved = 1'b1;
            if (m_n == 99) m_lose = 1'b1;
            else m_n = m_n + 1;
        end
        e.tc     = m_tc;
        e.tm     = m_tm;
        e.att    = {4'(m_n / 10), 4'(m_n % 10)};
        e.lose   = m_lose;
        e.solved = m_solved;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        submit = 1'b0;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got = sbq.pop_front();
            chk("total_correct",   {4'd0, total_correct},   {4'd0, got.tc});
            chk("total_misplaced", {4'd0, total_misplaced}, {4'd0, got.tm});
            chk("attempts",        attempts,                got.att);
            chk("lose",            {7'd0, lose},            {7'd0, got.lose});
            chk("solved",          {7'd0, solved},          {7'd0, got.solved});
        end
    endtask

    initial begin
        reset  = 1'b0;
        submit = 1'b0;
        sel    = 2'd0;
        guess  = 8'h00;
        code   = 8'h00;
        m_tc = 4'd0; m_tm = 4'd0; m_n = 0; m_lose = 1'b0; m_solved = 1'b0;

        //                sel    guess         code          en       c        m        cc    mc
        vecs[0] = '{2'd0, 8'b11_10_01_00, 8'b11_10_01_00, 4'b0001, 4'b1111, 4'b0000, 4'd4, 4'd0};
        vecs[1] = '{2'd1, 8'b00_01_10_11, 8'b11_10_01_00, 4'b0010, 4'b0000, 4'b1111, 4'd0, 4'd4};
        vecs[2] = '{2'd2, 8'b00_00_01_01, 8'b10_01_00_00, 4'b0100, 4'b0000, 4'b1101, 4'd0, 4'd3};
        vecs[3] = '{2'd3, 8'h55,          8'b00_00_01_01, 4'b1000, 4'b0011, 4'b0000, 4'd2, 4'd0};
        vecs[4] = '{2'd0, 8'hFF,          8'h00,          4'b0001, 4'b0000, 4'b0000, 4'd0, 4'd0};
        vecs[5] = '{2'd1, 8'b00_00_11_11, 8'b00_01_10_11, 4'b0010, 4'b1001, 4'b0000, 4'd2, 4'd0};

        // Reset state
        step(1'b1, 1'b0, 4'd0, 4'd0);

        // Combinational vectors, no clock needed
        for (int v = 0; v < 6; v++) begin
            sel   = vecs[v].sel;
            guess = vecs[v].guess;
            code  = vecs[v].code;
            #1;
            chk("enables",         {4'd0, enables},         {4'd0, vecs[v].en});
            chk("correct_flags",   {4'd0, correct_flags},   {4'd0, vecs[v].c});
            chk("misplaced_flags", {4'd0, misplaced_flags}, {4'd0, vecs[v].m});
            chk("correct_count",   {4'd0, correct_count},   {4'd0, vecs[v].cc});
            chk("misplaced_count", {4'd0, misplaced_count}, {4'd0, vecs[v].mc});
        end

        // Solving submit, then a submit that must be ignored
        step(1'b1, 1'b0, 4'd0, 4'd0);
        code  = 8'b11_10_01_00;
        guess = 8'b11_10_01_00;
        step(1'b0, 1'b1, 4'd4, 4'd0);
        chk("solved_attempts", attempts, 8'h01);
        guess = 8'b00_01_10_11;
        step(1'b0, 1'b1, 4'd0, 4'd4);
        step(1'b0, 1'b0, 4'd0, 4'd0);

        // Attempt counter up to and past 99 with a non-solving guess
        step(1'b1, 1'b0, 4'd0, 4'd0);
        for (int n = 1; n <= 99; n++) begin
            step(1'b0, 1'b1, 4'd0, 4'd4);
            if (n == 9)  chk("att_9",  attempts, 8'h09);
            if (n == 10) chk("att_10", attempts, 8'h10);
        end
        chk("att_99", attempts, 8'h99);
        chk("lose_at_99", {7'd0, lose}, 8'h00);
        step(1'b0, 1'b1, 4'd0, 4'd4);
        chk("lose_100", {7'd0, lose}, 8'h01);
        chk("att_100", attempts, 8'h99);
        guess = 8'b11_10_01_00;
        step(1'b0, 1'b1, 4'd4, 4'd0);
        step(1'b0, 1'b1, 4'd4, 4'd0);
        chk("solved_after_lose", {7'd0, solved}, 8'h00);

        // Reset together with submit mid-game
        step(1'b1, 1'b0, 4'd0, 4'd0);
        guess = 8'b00_01_10_11;
        for (int n = 0; n < 42; n++) step(1'b0, 1'b1, 4'd0, 4'd4);
        chk("att_42", attempts, 8'h42);
        step(1'b1, 1'b1, 4'd0, 4'd4);
        chk("reset_over_submit", attempts, 8'h00);
        step(1'b0, 1'b0, 4'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
